// File: rtl/hamming_score_if.sv
// Handshake bundle between the score driver and the hamming_score_accumulator.
interface hamming_score_if #(
    parameter int unsigned SUM_W = 6,
    parameter int unsigned CNT_W = 3
);
    logic             start;
    logic             hb_valid;
    logic [2:0]       hb;
    logic             busy;
    logic             done;
    logic [SUM_W-1:0] sum;
    logic             match;
    logic [2:0]       best;
    logic [CNT_W-1:0] best_idx;

    modport master (
        output start, hb_valid, hb,
        input  busy, done, sum, match, best, best_idx
    );

    modport slave (
        input  start, hb_valid, hb,
        output busy, done, sum, match, best, best_idx
    );
endinterface

// File: rtl/hamming_score_accumulator.sv
// Sums FRAME_LEN similarity scores per frame and flags a match when the total reaches THRESH.
// Define HAMMING_BEST_EN to also track the frame's max score and the index of its first occurrence.
module hamming_score_accumulator #(
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned THRESH    = 24,
    parameter int unsigned SUM_W     = 6,
    parameter int unsigned CNT_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    hamming_score_if.slave        bus
);

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    localparam logic [SUM_W-1:0] ThreshW = SUM_W'(THRESH);
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(FRAME_LEN - 1);

    state_e           state_q, state_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             match_q, match_d;

    logic [2:0]       sat;
    logic [SUM_W-1:0] sum_inc;
    logic             frame_start;
    logic             accept;

    // Illegal codes 5..7 clamp to the maximum legal score.
    assign sat         = (bus.hb > 3'd4) ? 3'd4 : bus.hb;
    assign sum_inc     = sum_q + SUM_W'(sat);
    assign frame_start = (state_q == StIdle) && bus.start;
    assign accept      = (state_q == StAccum) && bus.hb_valid;

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        match_d = match_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StAccum;
                    sum_d   = '0;
                    cnt_d   = '0;
                    match_d = 1'b0;
                end
            end
            StAccum: begin
                if (bus.hb_valid) begin
                    sum_d = sum_inc;
                    if (cnt_q == LastCnt) begin
                        state_d = StDone;
                        cnt_d   = '0;
                        match_d = (sum_inc >= ThreshW);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sum_q   <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
        end
    end

    assign bus.busy  = (state_q == StAccum);
    assign bus.done  = (state_q == StDone);
    assign bus.sum   = sum_q;
    assign bus.match = match_q;

`ifdef HAMMING_BEST_EN
    logic [2:0]       best_q, best_d;
    logic [CNT_W-1:0] best_idx_q, best_idx_d;

    // Strict greater-than keeps the index of the first occurrence on ties.
    always_comb begin
        best_d     = best_q;
        best_idx_d = best_idx_q;
        if (frame_start) begin
            best_d     = '0;
            best_idx_d = '0;
        end else if (accept && (sat > best_q)) begin
            best_d     = sat;
            best_idx_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            best_q     <= '0;
            best_idx_q <= '0;
        end else begin
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
        end
    end

    assign bus.best     = best_q;
    assign bus.best_idx = best_idx_q;
`else
    assign bus.best     = '0;
    assign bus.best_idx = '0;
`endif

endmodule

// File: tb/tb_hamming_score_accumulator.sv
// Randomized bench for hamming_score_accumulator, checked every cycle against a queue-based model.
module tb_hamming_score_accumulator;

    localparam int FrameLen = 8;
    localparam int Thresh   = 24;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    hamming_score_if #(.SUM_W(6), .CNT_W(3)) bus ();

    hamming_score_accumulator #(
        .FRAME_LEN (FrameLen),
        .THRESH    (Thresh),
        .SUM_W     (6),
        .CNT_W     (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: frame contents as a queue of clamped scores plus a few flags.
    int q[$];
    bit m_on;
    bit m_in_frame;
    bit m_done;
    bit m_match;

    function automatic int score_sat(input int h);
        return (h > 4) ? 4 : h;
    endfunction

    function automatic int q_sum();
        int s = 0;
        foreach (q[i]) s += q[i];
        return s;
    endfunction

    function automatic int q_best();
        int b = 0;
        foreach (q[i]) if (q[i] > b) b = q[i];
        return b;
    endfunction

    function automatic int q_best_idx();
        int b = q_best();
        foreach (q[i]) if (q[i] == b) return i;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_on       = 1'b1;
            m_in_frame = 1'b0;
            m_done     = 1'b0;
            m_match    = 1'b0;
            q.delete();
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (!m_in_frame) begin
            if (bus.start) begin
                q.delete();
                m_match    = 1'b0;
                m_in_frame = 1'b1;
            end
        end else if (bus.hb_valid) begin
            q.push_back(score_sat(int'(bus.hb)));
            if (q.size() == FrameLen) begin
                m_in_frame = 1'b0;
                m_done     = 1'b1;
                m_match    = (q_sum() >= Thresh);
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("busy",  32'(bus.busy),  32'(m_in_frame));
            chk("done",  32'(bus.done),  32'(m_done));
            chk("sum",   32'(bus.sum),   32'(q_sum()));
            chk("match", 32'(bus.match), 32'(m_match));
`ifdef HAMMING_BEST_EN
            chk("best",     32'(bus.best),     32'(q_best()));
            chk("best_idx", 32'(bus.best_idx), 32'(q_best_idx()));
`else
            chk("best",     32'(bus.best),     32'd0);
            chk("best_idx", 32'(bus.best_idx), 32'd0);
`endif
        end
    end

    task automatic step(input bit s, input bit v, input int h);
        bus.start    = s;
        bus.hb_valid = v;
        bus.hb       = 3'(h);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int s0, input int s1, input int s2, input int s3,
                             input int s4, input int s5, input int s6, input int s7);
        int v[8];
        v = '{s0, s1, s2, s3, s4, s5, s6, s7};
        step(1'b1, 1'b1, 4);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, v[i]);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_on   = 1'b0;
        rst    = 1'b1;
        bus.start = 1'b0; bus.hb_valid = 1'b0; bus.hb = 3'd0;
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        chk("rst_sum",   32'(bus.sum),   32'd0);
        chk("rst_busy",  32'(bus.busy),  32'd0);
        chk("rst_match", 32'(bus.match), 32'd0);
        rst = 1'b0;

        // 1: eight 4s back to back
        run_frame(4, 4, 4, 4, 4, 4, 4, 4);
        chk("t1_done",  32'(bus.done),  32'd1);
        chk("t1_busy",  32'(bus.busy),  32'd0);
        chk("t1_sum",   32'(bus.sum),   32'd32);
        chk("t1_match", 32'(bus.match), 32'd1);
        chk("t1_model", 32'(q_sum()),   32'd32);
        step(1'b0, 1'b0, 0);
        chk("t1_done_pulse", 32'(bus.done), 32'd0);
        chk("t1_hold_sum",   32'(bus.sum),  32'd32);

        // 2: threshold boundary
        run_frame(3, 3, 3, 3, 3, 3, 3, 3);
        chk("t2_sum24",   32'(bus.sum),   32'd24);
        chk("t2_match24", 32'(bus.match), 32'd1);
        step(1'b0, 1'b0, 0);
        run_frame(3, 3, 3, 2, 3, 3, 3, 3);
        chk("t2_sum23",   32'(bus.sum),   32'd23);
        chk("t2_match23", 32'(bus.match), 32'd0);
        step(1'b0, 1'b0, 0);

        // 3: illegal codes clamp
        run_frame(7, 7, 7, 7, 7, 7, 7, 7);
        chk("t3_sum_clamp", 32'(bus.sum), 32'd32);
        step(1'b0, 1'b0, 0);
        run_frame(0, 0, 0, 5, 0, 0, 0, 0);
        chk("t3_sum_five", 32'(bus.sum), 32'd4);
        step(1'b0, 1'b0, 0);

        // 4: gaps and start mid-frame
        step(1'b1, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 2);
            step(1'b1, 1'b0, 4);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1);
        chk("t4_busy_7", 32'(bus.busy), 32'd1);
        chk("t4_done_7", 32'(bus.done), 32'd0);
        step(1'b1, 1'b1, 1);
        chk("t4_done_8", 32'(bus.done), 32'd1);
        chk("t4_sum",    32'(bus.sum),  32'd12);
        step(1'b0, 1'b0, 0);

        // 5: reset mid-frame
        step(1'b1, 1'b0, 0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4);
        rst = 1'b1;
        step(1'b0, 1'b1, 4);
        rst = 1'b0;
        chk("t5_sum",  32'(bus.sum),  32'd0);
        chk("t5_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4);
        run_frame(1, 1, 1, 1, 1, 1, 1, 1);
        chk("t5_clean_sum", 32'(bus.sum), 32'd8);
        step(1'b0, 1'b0, 0);

        // 6: best tracking
        run_frame(1, 4, 2, 4, 0, 0, 0, 0);
`ifdef HAMMING_BEST_EN
        chk("t6_best",     32'(bus.best),     32'd4);
        chk("t6_best_idx", 32'(bus.best_idx), 32'd1);
`else
        chk("t6_best",     32'(bus.best),     32'd0);
        chk("t6_best_idx", 32'(bus.best_idx), 32'd0);
`endif
        step(1'b0, 1'b0, 0);

        // Random traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(99) == 0);
            step(bit'($urandom_range(3) == 0), bit'($urandom_range(3) != 0),
                 int'($urandom_range(7)));
        end
        rst = 1'b0;
        step(1'b0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
